// File: rtl/lemming_pkg.sv
// Shared encodings for the lemming walker and its patrol sequencer.
package lemming_pkg;

   localparam int LAP_W = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUN,
      ST_FALLING,
      ST_DONE,
      ST_SPLAT
   } patrol_state_t;

   // Walker's own state encoding, kept here so both blocks agree on it.
   typedef enum logic [1:0] {
      WLK_LEFT,
      WLK_RIGHT,
      WLK_FALL_L,
      WLK_FALL_R
   } walker_state_t;

   // A lap target of zero still means one lap.
   function automatic logic [LAP_W-1:0] norm_target(input logic [LAP_W-1:0] t);
      return (t == '0) ? LAP_W'(1) : t;
   endfunction

endpackage

// File: rtl/patrol_controller_if.sv
// Link between the patrol sequencer (master) and the walker (slave).
interface patrol_controller_if;
   logic walk_left;
   logic walk_right;
   logic aaah;
   logic walker_rst;
   logic turn_left;
   logic turn_right;

   modport master (
      input  walk_left, walk_right, aaah,
      output walker_rst, turn_left, turn_right
   );

   modport slave (
      output walk_left, walk_right, aaah,
      input  walker_rst, turn_left, turn_right
   );
endinterface

// File: rtl/patrol_controller.sv
// Patrol sequencer for one lemming walker: tracks position in a bounded
// corridor, issues turns at the bounds, counts laps, supervises falls.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | walker held in reset, waiting for start
// ST_RUN     | walker released, position tracked, turns issued at bounds
// ST_FALLING | walker falling, position frozen, fall length counted
// ST_DONE    | target laps completed, walker held in reset
// ST_SPLAT   | fall exceeded limit, walker held in reset
module patrol_controller
   import lemming_pkg::*;
#(
   parameter int POS_W       = 8,
   parameter int LEFT_BOUND  = 0,
   parameter int RIGHT_BOUND = 15,
   parameter int FALL_LIMIT  = 20,
   parameter int FALL_W      = 5
) (
   input  logic                clk,
   input  logic                areset_n,
   input  logic                start,
   input  logic [LAP_W-1:0]    lap_target,
   patrol_controller_if.master wlk,
   output logic [POS_W-1:0]    pos,
   output logic [LAP_W-1:0]    laps,
   output logic                busy,
   output logic                done,
   output logic                splat
);

   localparam logic [POS_W-1:0]  LEFT_P  = POS_W'(LEFT_BOUND);
   localparam logic [POS_W-1:0]  RIGHT_P = POS_W'(RIGHT_BOUND);
   localparam logic [FALL_W-1:0] LIMIT_P = FALL_W'(FALL_LIMIT);

   patrol_state_t     state_q, state_d;
   logic [POS_W-1:0]  pos_q, pos_d;
   logic [LAP_W-1:0]  laps_q, laps_d;
   logic [LAP_W-1:0]  target_q, target_d;
   logic [FALL_W-1:0] fall_cnt_q, fall_cnt_d;
   logic              seen_right_q, seen_right_d;
   logic              turn_l, turn_r, walker_rst_c, busy_c, done_c, splat_c;

   // State and datapath registers; reset pulls the walker back immediately.
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         state_q      <= ST_IDLE;
         pos_q        <= LEFT_P;
         laps_q       <= '0;
         target_q     <= '0;
         fall_cnt_q   <= '0;
         seen_right_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pos_q        <= pos_d;
         laps_q       <= laps_d;
         target_q     <= target_d;
         fall_cnt_q   <= fall_cnt_d;
         seen_right_q <= seen_right_d;
      end
   end

   // Next-state, datapath updates and outputs.
   always_comb begin
      state_d      = state_q;
      pos_d        = pos_q;
      laps_d       = laps_q;
      target_d     = target_q;
      fall_cnt_d   = fall_cnt_q;
      seen_right_d = seen_right_q;
      turn_l       = 1'b0;
      turn_r       = 1'b0;
      walker_rst_c = 1'b1;
      busy_c       = 1'b0;
      done_c       = 1'b0;
      splat_c      = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE, ST_SPLAT: begin
            done_c  = (state_q == ST_DONE);
            splat_c = (state_q == ST_SPLAT);
            if (start) begin
               state_d      = ST_RUN;
               pos_d        = LEFT_P;
               laps_d       = '0;
               fall_cnt_d   = '0;
               seen_right_d = 1'b0;
               target_d     = norm_target(lap_target);
            end
         end
         ST_RUN: begin
            walker_rst_c = 1'b0;
            busy_c       = 1'b1;
            turn_l       = wlk.walk_right && (pos_q == RIGHT_P);
            turn_r       = wlk.walk_left  && (pos_q == LEFT_P);
            // A fall overrides any position or lap bookkeeping this edge.
            if (wlk.aaah) begin
               state_d    = ST_FALLING;
               fall_cnt_d = FALL_W'(1);
            end else begin
               if (wlk.walk_right && (pos_q < RIGHT_P)) pos_d = pos_q + POS_W'(1);
               if (wlk.walk_left  && (pos_q > LEFT_P))  pos_d = pos_q - POS_W'(1);
               if (turn_l) seen_right_d = 1'b1;
               if (turn_r && seen_right_q) begin
                  laps_d       = laps_q + LAP_W'(1);
                  seen_right_d = 1'b0;
                  if (laps_d == target_q) state_d = ST_DONE;
               end
            end
         end
         ST_FALLING: begin
            walker_rst_c = 1'b0;
            busy_c       = 1'b1;
            if (wlk.aaah) begin
               fall_cnt_d = fall_cnt_q + FALL_W'(1);
               if (fall_cnt_d >= LIMIT_P) state_d = ST_SPLAT;
            end else begin
               state_d    = ST_RUN;
               fall_cnt_d = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign wlk.turn_left  = turn_l;
   assign wlk.turn_right = turn_r;
   assign wlk.walker_rst = walker_rst_c;
   assign pos            = pos_q;
   assign laps           = laps_q;
   assign busy           = busy_c;
   assign done           = done_c;
   assign splat          = splat_c;

endmodule

// File: tb/tb_patrol_controller.sv
// Scoreboard bench for patrol_controller driving a behavioural walker.
module tb_patrol_controller;

   localparam int L   = 0;
   localparam int R   = 3;
   localparam int LIM = 20;

   typedef struct packed {
      logic right;
      logic falling;
   } walker_t;

   typedef struct packed {
      logic       wrst;
      logic       tl;
      logic       tr;
      logic       busy;
      logic       done;
      logic       splat;
      logic [3:0] laps;
      logic [7:0] pos;
   } obs_t;

   logic       clk = 1'b0;
   logic       areset_n = 1'b0;
   logic       start = 1'b0;
   logic [3:0] lap_target = 4'd0;
   logic       ground = 1'b1;
   logic [7:0] pos;
   logic [3:0] laps;
   logic       busy, done, splat;

   int n_total = 0;
   int n_pass  = 0;

   obs_t exp_q[$];

   patrol_controller_if wif();

   patrol_controller #(
      .POS_W(8), .LEFT_BOUND(L), .RIGHT_BOUND(R), .FALL_LIMIT(LIM), .FALL_W(5)
   ) dut (
      .clk(clk), .areset_n(areset_n), .start(start), .lap_target(lap_target),
      .wlk(wif.master), .pos(pos), .laps(laps), .busy(busy), .done(done), .splat(splat)
   );

   always #5 clk = ~clk;

   // Walker behaviour: reset forces walk-left, falls when ground is missing,
   // lands walking left, otherwise obeys turn commands.
   function automatic walker_t walker_next(walker_t w, logic rst, logic tl, logic tr, logic gnd);
      walker_t n;
      n = w;
      if (rst) begin
         n.right = 1'b0; n.falling = 1'b0;
      end else if (w.falling) begin
         if (gnd) begin n.falling = 1'b0; n.right = 1'b0; end
      end else if (!gnd) begin
         n.falling = 1'b1;
      end else if (tl) begin
         n.right = 1'b0;
      end else if (tr) begin
         n.right = 1'b1;
      end
      return n;
   endfunction

   walker_t env_w = '0;
   assign wif.walk_left  = !env_w.falling && !env_w.right;
   assign wif.walk_right = !env_w.falling &&  env_w.right;
   assign wif.aaah       =  env_w.falling;

   initial begin
      logic s_rst, s_tl, s_tr, s_gnd;
      forever begin
         @(posedge clk);
         s_rst = wif.walker_rst; s_tl = wif.turn_left; s_tr = wif.turn_right; s_gnd = ground;
         #1;
         env_w = walker_next(env_w, s_rst, s_tl, s_tr, s_gnd);
      end
   end

   // Reference model: mode 0 idle, 1 run, 2 falling, 3 done, 4 splat.
   int      m_mode = 0;
   int      m_pos = L;
   int      m_laps = 0;
   int      m_target = 0;
   int      m_cnt = 0;
   bit      m_seen = 0;
   walker_t m_w = '0;

   function automatic obs_t model_obs();
      obs_t o;
      bit wl, wr;
      wl = !m_w.falling && !m_w.right;
      wr = !m_w.falling &&  m_w.right;
      o.wrst  = (m_mode == 0) || (m_mode == 3) || (m_mode == 4);
      o.tl    = (m_mode == 1) && wr && (m_pos == R);
      o.tr    = (m_mode == 1) && wl && (m_pos == L);
      o.busy  = (m_mode == 1) || (m_mode == 2);
      o.done  = (m_mode == 3);
      o.splat = (m_mode == 4);
      o.laps  = 4'(m_laps);
      o.pos   = 8'(m_pos);
      return o;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_pos = L; m_laps = 0; m_target = 0; m_cnt = 0; m_seen = 0;
   endtask

   task automatic model_step(input bit st, input logic [3:0] tgt, input bit gnd, input bit rst_n);
      obs_t    o;
      walker_t nw;
      bit      wl, wr;
      o  = model_obs();
      wl = !m_w.falling && !m_w.right;
      wr = !m_w.falling &&  m_w.right;
      nw = walker_next(m_w, o.wrst, o.tl, o.tr, gnd);
      if (!rst_n) begin
         model_reset();
      end else if (m_mode == 1) begin
         if (m_w.falling) begin
            m_mode = 2; m_cnt = 1;
         end else begin
            if (wr) m_pos = (m_pos + 1 > R) ? R : m_pos + 1;
            if (wl) m_pos = (m_pos - 1 < L) ? L : m_pos - 1;
            if (o.tl) m_seen = 1;
            if (o.tr && m_seen) begin
               m_laps++; m_seen = 0;
               if (m_laps == m_target) m_mode = 3;
            end
         end
      end else if (m_mode == 2) begin
         if (m_w.falling) begin
            m_cnt++;
            if (m_cnt >= LIM) m_mode = 4;
         end else begin
            m_mode = 1; m_cnt = 0;
         end
      end else if (st) begin
         m_mode = 1; m_pos = L; m_laps = 0; m_cnt = 0; m_seen = 0;
         m_target = (tgt == 4'd0) ? 1 : int'(tgt);
      end
      m_w = nw;
   endtask

   function automatic obs_t dut_obs();
      return {wif.walker_rst, wif.turn_left, wif.turn_right, busy, done, splat, laps, pos};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Monitor: one expected observation per clock, compared mid-cycle.
   initial begin
      obs_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("cycle_outputs", 32'(dut_obs()), 32'(e));
         end
      end
   end

   task automatic cycle(input bit st, input logic [3:0] tgt, input bit gnd);
      start = st; lap_target = tgt; ground = gnd;
      @(posedge clk);
      model_step(st, tgt, gnd, areset_n);
      exp_q.push_back(model_obs());
      #1;
   endtask

   // Must be called right after cycle() returns: drops reset between edges.
   task automatic async_reset_check();
      obs_t r;
      r = '0; r.wrst = 1'b1; r.pos = 8'(L);
      #2; areset_n = 1'b0; #1;
      check("reset_immediate", 32'(dut_obs()), 32'(r));
      model_reset();
      void'(exp_q.pop_back());
      exp_q.push_back(model_obs());
      repeat (2) cycle(1'b0, 4'd0, 1'b1);
      areset_n = 1'b1;
   endtask

   initial begin
      int drop_left;
      bit gnd;

      repeat (3) cycle(1'b0, 4'd0, 1'b1);
      areset_n = 1'b1;
      repeat (3) cycle(1'b1 & 1'b0, 4'd0, 1'b1);

      // Two laps on a 0..3 corridor.
      for (int k = 0; k <= 17; k++) begin
         cycle(k == 0, 4'd2, 1'b1);
         #1;
         check("turn_right_k", 32'(wif.turn_right), 32'(k == 0 || k == 8 || k == 16));
         check("turn_left_k",  32'(wif.turn_left),  32'(k == 4 || k == 12));
         if (k == 9)  check("laps_after_e9", 32'(laps), 32'd1);
         if (k == 17) begin
            check("done_e17", 32'(done), 32'd1);
            check("laps_e17", 32'(laps), 32'd2);
            check("wrst_e17", 32'(wif.walker_rst), 32'd1);
         end
      end

      // Zero target behaves as one lap.
      repeat (2) cycle(1'b0, 4'd0, 1'b1);
      for (int k = 0; k <= 9; k++) begin
         cycle(k == 0, 4'd0, 1'b1);
         #1;
         if (k == 8) check("tgt0_not_done_e8", 32'(done), 32'd0);
         if (k == 9) check("tgt0_done_e9", 32'(done), 32'd1);
      end

      // Short fall at pos 2 with stray starts during RUN and FALLING.
      repeat (2) cycle(1'b0, 4'd0, 1'b1);
      for (int k = 0; k <= 40; k++) begin
         cycle(k == 0 || k == 2 || k == 6, 4'd1, !(k >= 3 && k <= 7));
         #1;
         if (k == 5) begin
            check("fall_pos_held", 32'(pos), 32'd2);
            check("fall_no_turns", 32'({wif.turn_left, wif.turn_right}), 32'd0);
            check("fall_busy", 32'(busy), 32'd1);
         end
         if (k == 9)  check("resume_pos_e9", 32'(pos), 32'd2);
         if (k == 10) check("resume_left_e10", 32'(pos), 32'd1);
      end

      // Long fall ends in splat; a new start clears it.
      cycle(1'b1, 4'd3, 1'b1);
      repeat (5)  cycle(1'b0, 4'd3, 1'b1);
      repeat (30) cycle(1'b0, 4'd3, 1'b0);
      #1;
      check("splat_set", 32'(splat), 32'd1);
      check("splat_wrst", 32'(wif.walker_rst), 32'd1);
      repeat (2) cycle(1'b0, 4'd0, 1'b1);
      cycle(1'b1, 4'd2, 1'b1);
      #1;
      check("restart_splat_clr", 32'(splat), 32'd0);
      check("restart_laps", 32'(laps), 32'd0);

      // Asynchronous reset mid-RUN, then IDLE holds.
      repeat (6) cycle(1'b0, 4'd0, 1'b1);
      async_reset_check();
      repeat (5) cycle(1'b0, 4'd0, 1'b1);
      #1;
      check("idle_after_reset", 32'(busy), 32'd0);

      // Randomised traffic against the model.
      drop_left = 0;
      for (int i = 0; i < 2500; i++) begin
         if (drop_left > 0) begin
            gnd = 1'b0; drop_left--;
         end else begin
            gnd = 1'b1;
            if ($urandom_range(0, 39) == 0) drop_left = $urandom_range(1, 30);
         end
         cycle($urandom_range(0, 19) == 0, 4'($urandom_range(0, 15)), gnd);
         if ($urandom_range(0, 299) == 0) async_reset_check();
      end

      repeat (2) cycle(1'b0, 4'd0, 1'b1);
      #10;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/patrol_controller.md
# patrol_controller

Sequencer for one lemming walker FSM, i.e. a walker with `walk_left`/`walk_right`/`aaah` status outputs and `turn_left`/`turn_right`/`areset` inputs.
- Holds the walker in reset until started, then tracks its position along a bounded corridor.
- Issues turn pulses at the corridor bounds and counts completed laps.
- Supervises falls, and declares a splat when a fall exceeds a cycle limit.
- Sits between the top-level command logic and the walker instance.

## Interface
- `POS_W`, 8, position register width
- `LEFT_BOUND`, 0, leftmost corridor position
- `RIGHT_BOUND`, 15, rightmost corridor position; must be > `LEFT_BOUND`
- `FALL_LIMIT`, 20, fall length in cycles that causes a splat
- `FALL_W`, 5, fall counter width; must hold `FALL_LIMIT`
- `clk`  in  1  single clock; all state updates on its rising edge
- `areset_n`  in  1  reset; asynchronous, active-low
- `start`  in  1  begin a patrol; sampled only in IDLE, DONE, SPLAT
- `lap_target`  in  4  laps to complete; sampled on `start`
- `walk_left`, `walk_right`, `aaah`  in  1 each  walker status (registered in walker)
- `walker_rst`  out  1  active-high reset to walker; forces walker to walk-left
- `turn_left`, `turn_right`  out  1 each  single-cycle turn commands to walker
- `pos`  out  POS_W  current tracked position
- `laps`  out  4  completed laps
- `busy`  out  1  high in RUN or FALLING
- `done`  out  1  high in DONE
- `splat`  out  1  high in SPLAT

## Operation
- States: IDLE, RUN, FALLING, DONE, SPLAT.
- Reset values: state IDLE, `pos`=`LEFT_BOUND`, `laps`=0, fall count 0, `seen_right`=0, latched target 0.
- Outputs in reset/IDLE: `walker_rst`=1; turns, `busy`, `done`, `splat` all 0.
- `walker_rst`=1 in IDLE, DONE and SPLAT; 0 in RUN and FALLING.

IDLE, DONE or SPLAT + `start`:
- Go to RUN.
- Load `pos`=`LEFT_BOUND`, clear `laps`, clear fall count, clear `seen_right`.
- Latch `lap_target`. A `lap_target` of 0 is treated as 1.

RUN:
- `turn_left` = `walk_right` && `pos`==`RIGHT_BOUND` (combinational from registered values).
- `turn_right` = `walk_left` && `pos`==`LEFT_BOUND` (combinational).
- Each edge with `walk_right`: `pos`+1, saturating at `RIGHT_BOUND`.
- Each edge with `walk_left`: `pos`-1, saturating at `LEFT_BOUND`.
- `turn_left` asserted → set `seen_right`.
- `turn_right` asserted and `seen_right`=1 → `laps`+1 and clear `seen_right`. If the new value equals the latched target, go to DONE.
- `aaah`=1 → go to FALLING with fall count = 1. `pos` is held; aaah has priority over any position or lap update.

FALLING:
- Turns are 0 and `pos` is frozen.
- Each edge with `aaah`=1: fall count +1.
- Fall count reaches `FALL_LIMIT` while `aaah`=1 → go to SPLAT.
- `aaah`=0 before the limit → return to RUN and clear fall count. The walker resumes walking left; `pos` and `seen_right` are kept.

DONE and SPLAT hold `pos` and `laps` until the next `start` or reset.

`start` while `busy` is ignored.

Reset mid-operation returns to IDLE immediately (asynchronously); `walker_rst` rises in the same instant.

## Timing
- Turn pulses are combinational and one cycle wide; the walker changes direction on the same edge.
- Edge E0 samples `start`. `walker_rst` falls after E0, and the first `turn_right` pulse is in the cycle after E0.
- One lap takes 2×(`RIGHT_BOUND`−`LEFT_BOUND`+1) cycles.
- `done` rises on the edge that counts the final lap.
- Fall detection: FALLING is entered on the edge after `aaah` first reads 1.
- SPLAT is entered `FALL_LIMIT`−1 edges after FALLING is entered if `aaah` stays high.

## Structure
- Shared package `lemming_pkg`:
  - state encoding enum `patrol_state_t`
  - walker state encodings shared with the walker block
- No sub-module required; the fall counter stays inline.
- Top level instantiates `patrol_controller` beside the walker.

## Test plan
- Bounds 0..3, `lap_target`=2, ground always 1, `start` at E0:
  - `turn_right` in cycles after E0, E8 and E16
  - `turn_left` after E4 and E12
  - `laps`=1 at E9, `done`=1 and `laps`=2 at E17
  - `walker_rst` back to 1 at E17
- `lap_target`=0 → completes after exactly one lap (same as 1).
- Ground dropped for 5 cycles mid-RUN at `pos`=2 with `FALL_LIMIT`=20:
  - FALLING entered, `pos` stays 2, no turns
  - return to RUN, walker resumes walking left from `pos` 2
- Ground dropped for 30 cycles → SPLAT with `splat`=1 and `walker_rst`=1; a later `start` clears `splat` and restarts with `laps`=0.
- `start` pulsed during RUN and during FALLING → no effect on state, `pos` or `laps`.
- `areset_n` asserted low mid-RUN between clock edges:
  - all outputs take reset values immediately
  - after release, IDLE holds until `start`
